// File: rtl/zmem_sized_if.sv
// Request/response bundle between the load/store unit and zmem_sized.
// Latency: none, this is wiring only.
// Backpressure: req_ready from the memory side qualifies req_valid.
interface zmem_sized_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // Load/store unit side.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/zmem_sized.sv
// Byte-addressed data memory with byte/half/word lane steering, sign extension and misalignment errors.
// Latency: response valid RD_LAT cycles after the accept edge (RD_LAT=1 -> next cycle).
// Backpressure: none; req_ready is low only during reset, one request per cycle.
module zmem_sized #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  zmem_sized_if.slave  bus
);
  localparam int WORDS = 1 << (ADDR_W - 2);

  // Storage is deliberately not reset so contents survive rst.
  logic [31:0] mem_q [WORDS];

  logic              accept;
  logic              req_err;
  logic [ADDR_W-3:0] idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_val;

  // Result pipeline: one {valid, err, rdata} slot per latency stage.
  logic [RD_LAT-1:0]       vld_q, vld_d;
  logic [RD_LAT-1:0]       err_q, err_d;
  logic [RD_LAT-1:0][31:0] rdata_q, rdata_d;

  assign bus.req_ready = !rst;
  assign accept        = bus.req_valid && !rst;
  assign idx           = bus.req_addr[ADDR_W-1:2];
  assign lane          = bus.req_addr[1:0];

  // Decode alignment errors, byte enables and replicated store data.
  always_comb begin
    req_err   = 1'b0;
    be        = 4'b0000;
    wdata_rep = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        req_err   = lane[0];
        be        = 4'b0011 << {lane[1], 1'b0};
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      2'd2: begin
        req_err   = (lane != 2'b00);
        be        = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  always_comb begin
    rd_word  = mem_q[idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (bus.req_size)
      2'd0:    load_val = {{24{bus.req_signed & rd_shift[7]}},  rd_shift[7:0]};
      2'd1:    load_val = {{16{bus.req_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Store path: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Next-state of the result pipeline; idle slots carry zeros so outputs stay 0 when not valid.
  always_comb begin
    vld_d      = '0;
    err_d      = '0;
    rdata_d    = '0;
    vld_d[0]   = accept;
    err_d[0]   = accept && req_err;
    rdata_d[0] = (accept && !bus.req_write && !req_err) ? load_val : 32'h0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      err_d[i]   = err_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
  end

  // Advance the pipeline; reset drops every in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rsp_valid = vld_q[RD_LAT-1];
  assign bus.rsp_err   = err_q[RD_LAT-1];
  assign bus.rsp_rdata = rdata_q[RD_LAT-1];
endmodule
